sap_ram_loader: RTL

//  Sequences ram_16x8 in program mode: accepts (address, data) words over a valid/ready

---
 rtl/sap_ram_loader.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sap_ram_loader.sv
// sap_ram_loader
//   Program-mode sequencer for ram_16x8. Accepts (address, data) words from the
//   host/debug front-end over a valid/ready handshake, strobes each word into the
//   RAM and, in the verify build, reads it back and compares it. Program mode is
//   released when the session ends cleanly, errors out or is aborted. The normal
//   controller owns the RAM only while this block is idle.
//
//   Build option: define SAP_LOADER_VERIFY_EN to add the READ/CHECK readback
//   states. Without it the read strobe is tied low, i_ram_data is ignored and
//   only out-of-range addresses can raise an error.
//
// Ports
//   i_clk, i_reset_n          clock; synchronous active-low reset
//   i_start, i_abort          session start (IDLE/ERROR only) / abandon session
//   i_wr_valid/addr/data/last word offer from the host
//   o_wr_ready                word accepted this cycle (ACCEPT state only)
//   o_ram_program_mode        RAM held in program mode
//   o_ram_address             RAM address (latched word address)
//   o_ram_program_data        RAM write data (latched word data)
//   o_ram_write_enable        RAM write strobe, WRITE_CYCLES cycles per word
//   o_ram_read_enable         RAM readback strobe
//   i_ram_data                RAM read data (verify build only)
//   o_busy, o_done            session active / one-cycle clean-finish pulse
//   o_error, o_error_addr     sticky error flag and offending address
//   o_word_count              words written this session, saturating at DEPTH
module sap_ram_loader #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int WRITE_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_last,
  output logic              o_wr_ready,
  output logic              o_ram_program_mode,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [DATA_W-1:0] o_ram_program_data,
  output logic              o_ram_write_enable,
  output logic              o_ram_read_enable,
  input  logic [DATA_W-1:0] i_ram_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_error_addr,
  output logic [ADDR_W:0]   o_word_count
);

  localparam int WC_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_WRITE, S_READ, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic              error_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [ADDR_W:0]   count_q;
  logic [WC_W-1:0]   wcnt_q;

  logic addr_ok;
  logic wcnt_last;
  logic accept;
  logic clear;
  logic set_range_err;
  logic set_chk_err;
  logic write_done;

  assign addr_ok   = ({1'b0, i_wr_addr} < (ADDR_W+1)'(DEPTH));
  assign wcnt_last = (wcnt_q == WC_W'(WRITE_CYCLES - 1));

  // Next-state and per-cycle control; abort overrides every transition and
  // suppresses the side effects of the cycle it lands in.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    clear         = 1'b0;
    set_range_err = 1'b0;
    set_chk_err   = 1'b0;
    write_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_ACCEPT;
          clear   = 1'b1;
        end
      end
      S_ACCEPT: begin
        if (i_wr_valid) begin
          if (addr_ok) begin
            accept  = 1'b1;
            state_d = S_WRITE;
          end else begin
            set_range_err = 1'b1;
            state_d       = S_ERROR;
          end
        end
      end
      S_WRITE: begin
        if (wcnt_last) begin
          write_done = 1'b1;
`ifdef SAP_LOADER_VERIFY_EN
          state_d = S_READ;
`else
          state_d = last_q ? S_DONE : S_ACCEPT;
`endif
        end
      end
`ifdef SAP_LOADER_VERIFY_EN
      S_READ: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (i_ram_data != data_q) begin
          set_chk_err = 1'b1;
          state_d     = S_ERROR;
        end else begin
          state_d = last_q ? S_DONE : S_ACCEPT;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (i_start) begin
          state_d = S_ACCEPT;
          clear   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (i_abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      accept        = 1'b0;
      clear         = 1'b0;
      set_range_err = 1'b0;
      set_chk_err   = 1'b0;
      write_done    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      count_q    <= '0;
      wcnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        error_q    <= 1'b0;
        err_addr_q <= '0;
        count_q    <= '0;
      end
      if (accept) begin
        addr_q <= i_wr_addr;
        data_q <= i_wr_data;
        last_q <= i_wr_last;
      end
      if (set_range_err) begin
        error_q    <= 1'b1;
        err_addr_q <= i_wr_addr;
      end
      if (set_chk_err) begin
        error_q    <= 1'b1;
        err_addr_q <= addr_q;
      end
      // Strobe-length counter restarts whenever WRITE is entered or left.
      if ((state_q == S_WRITE) && (state_d == S_WRITE))
        wcnt_q <= wcnt_q + WC_W'(1);
      else
        wcnt_q <= '0;
      if (write_done && (count_q < (ADDR_W+1)'(DEPTH)))
        count_q <= count_q + (ADDR_W+1)'(1);
    end
  end

  // Outputs decode from registered state so reset clears them at the same edge.
  assign o_wr_ready         = (state_q == S_ACCEPT);
  assign o_ram_program_mode = (state_q == S_ACCEPT) || (state_q == S_WRITE) ||
                              (state_q == S_READ)   || (state_q == S_CHECK);
  assign o_ram_write_enable = (state_q == S_WRITE);
`ifdef SAP_LOADER_VERIFY_EN
  assign o_ram_read_enable  = (state_q == S_READ);
`else
  logic unused_ram_data;
  assign unused_ram_data    = ^i_ram_data;
  assign o_ram_read_enable  = 1'b0;
`endif
  assign o_busy             = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign o_done             = (state_q == S_DONE);
  assign o_ram_address      = addr_q;
  assign o_ram_program_data = data_q;
  assign o_error            = error_q;
  assign o_error_addr       = err_addr_q;
  assign o_word_count       = count_q;

endmodule
